// File: rtl/ctrl_frame_decoder.sv
// ctrl_frame_decoder
//
// Turns the UART receiver's byte stream into validated controller commands.
// A frame is three bytes: HEADER, command, checksum, where the checksum is the
// bitwise inverse of the command. The last good command is held on o_cmd until
// a newer good frame replaces it. If no good frame arrives for LINK_TIMEOUT
// cycles, the command is cleared so that a stalled link cannot leave a button
// held down.
//
// Optional build macro: CTRL_FRAME_STATS_EN
//   defined   : o_err_cnt is a saturating count of checksum failures plus
//               inter-byte gap timeouts.
//   undefined : no error counter is built and o_err_cnt is tied to zero.
//
// Ports:
//   i_clk      receiver clock
//   i_rst_n    asynchronous active-low reset
//   i_data     received byte, sampled on the rising edge of i_valid
//   i_valid    byte-valid from the receiver; may stay high for several cycles
//   o_cmd      last validated command byte
//   o_cmd_stb  one-cycle pulse when a good frame updates o_cmd
//   o_press    bits that rose in o_cmd, pulsed together with o_cmd_stb
//   o_link_ok  high while good frames keep arriving within LINK_TIMEOUT
//   o_err_cnt  saturating count of rejected frames (zero without the macro)

module ctrl_frame_decoder #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         GAP_TIMEOUT  = 3226,
  parameter int         LINK_TIMEOUT = 322600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_cmd,
  output logic       o_cmd_stb,
  output logic [7:0] o_press,
  output logic       o_link_ok,
  output logic [7:0] o_err_cnt
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);

  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_LAST = LW'(LINK_TIMEOUT - 1);
  localparam logic [LW-1:0] LINK_MAX  = LW'(LINK_TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_HDR,
    GET_CMD,
    GET_CHK
  } state_t;

  state_t        state;
  logic          valid_d;
  logic [7:0]    cmd_tmp;
  logic [GW-1:0] gap_cnt;
  logic [LW-1:0] link_cnt;

  logic strobe;
  logic chk_ok;
  logic good_frame;
  logic gap_expired;
  logic link_expiring;

  // A long valid pulse must count as one byte, so only its rising edge is used.
  assign strobe        = i_valid & ~valid_d;
  assign chk_ok        = (i_data == ~cmd_tmp);
  assign good_frame    = strobe && (state == GET_CHK) && chk_ok;
  // The gap timer only runs mid-frame; a strobe in the same cycle restarts it.
  assign gap_expired   = !strobe && (state != WAIT_HDR) && (gap_cnt == GAP_LAST);
  // True only on the single cycle the link timer steps onto its limit.
  assign link_expiring = (link_cnt == LINK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= WAIT_HDR;
      valid_d   <= 1'b0;
      cmd_tmp   <= 8'h00;
      gap_cnt   <= '0;
      link_cnt  <= '0;
      o_cmd     <= 8'h00;
      o_cmd_stb <= 1'b0;
      o_press   <= 8'h00;
      o_link_ok <= 1'b0;
    end else begin
      valid_d   <= i_valid;
      o_cmd_stb <= 1'b0;
      o_press   <= 8'h00;

      case (state)
        WAIT_HDR: begin
          gap_cnt <= '0;
          if (strobe && (i_data == HEADER)) begin
            state <= GET_CMD;
          end
        end
        GET_CMD: begin
          if (strobe) begin
            cmd_tmp <= i_data;
            gap_cnt <= '0;
            state   <= GET_CHK;
          end else if (gap_expired) begin
            gap_cnt <= '0;
            state   <= WAIT_HDR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        GET_CHK: begin
          if (strobe) begin
            gap_cnt <= '0;
            // A failing checksum byte that is itself a header starts a new frame.
            if (!chk_ok && (i_data == HEADER)) begin
              state <= GET_CMD;
            end else begin
              state <= WAIT_HDR;
            end
          end else if (gap_expired) begin
            gap_cnt <= '0;
            state   <= WAIT_HDR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          gap_cnt <= '0;
          state   <= WAIT_HDR;
        end
      endcase

      // A good frame takes priority over a link timeout in the same cycle.
      if (good_frame) begin
        o_cmd     <= cmd_tmp;
        o_cmd_stb <= 1'b1;
        o_press   <= cmd_tmp & ~o_cmd;
        o_link_ok <= 1'b1;
        link_cnt  <= '0;
      end else begin
        if (link_cnt != LINK_MAX) begin
          link_cnt <= link_cnt + 1'b1;
        end
        if (link_expiring) begin
          o_cmd     <= 8'h00;
          o_link_ok <= 1'b0;
        end
      end
    end
  end

`ifdef CTRL_FRAME_STATS_EN
  logic       err_event;
  logic [7:0] err_cnt;

  // Header mismatches while idle are ordinary line noise and are not counted.
  assign err_event = (strobe && (state == GET_CHK) && !chk_ok) || gap_expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt <= 8'h00;
    end else if (err_event && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ctrl_frame_decoder.sv
// tb_ctrl_frame_decoder
//
// Self-checking bench for ctrl_frame_decoder. Directed vectors come from a
// table of byte sequences with hand-derived results; hand-written sequences
// cover gap timeouts, the link timeout, reset in mid-frame and error counter
// saturation; a random byte stream is followed by a queue-based reference
// model that is compared against the DUT on every cycle.
// Builds with or without CTRL_FRAME_STATS_EN.

module tb_ctrl_frame_decoder;

  localparam int         GAP  = 3226;
  localparam int         LINK = 8000;
  localparam logic [7:0] HDR  = 8'hA5;

`ifdef CTRL_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic [7:0] o_cmd;
  logic       o_cmd_stb;
  logic [7:0] o_press;
  logic       o_link_ok;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  ctrl_frame_decoder #(
    .HEADER      (HDR),
    .GAP_TIMEOUT (GAP),
    .LINK_TIMEOUT(LINK)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (data),
    .i_valid  (valid),
    .o_cmd    (o_cmd),
    .o_cmd_stb(o_cmd_stb),
    .o_press  (o_press),
    .o_link_ok(o_link_ok),
    .o_err_cnt(o_err_cnt)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: bytes of the frame in progress are kept in a queue and
  // judged once three have arrived; time is tracked as absolute clock edges.
  logic [7:0] m_q[$];
  int         m_cyc;
  int         m_last_strobe;
  int         m_last_good;
  int         m_errs;
  logic       m_prev_v;
  logic [7:0] m_cmd;
  logic [7:0] m_press;
  logic       m_stb;
  logic       m_link;

  // Per-window observation of the DUT.
  int         win_stb;
  logic [7:0] win_press;
  bit         win_ok;
  string      win_msg;

  function automatic logic [7:0] err_exp(input int n);
    if (!STATS) return 8'h00;
    if (n >= 255) return 8'hFF;
    return 8'(n);
  endfunction

  function void model_reset();
    m_q.delete();
    m_cyc         = 0;
    m_last_strobe = 0;
    m_last_good   = 0;
    m_errs        = 0;
    m_prev_v      = 1'b0;
    m_cmd         = 8'h00;
    m_press       = 8'h00;
    m_stb         = 1'b0;
    m_link        = 1'b0;
  endfunction

  function void model_step(input logic v, input logic [7:0] d);
    logic       strobe;
    logic       good;
    logic [7:0] newc;
    logic [7:0] inv;
    m_cyc++;
    m_stb   = 1'b0;
    m_press = 8'h00;
    good    = 1'b0;
    newc    = 8'h00;
    strobe  = v && !m_prev_v;
    m_prev_v = v;
    if (strobe) begin
      m_last_strobe = m_cyc;
      m_q.push_back(d);
      if (m_q.size() == 1 && d != HDR) begin
        m_q.delete();
      end else if (m_q.size() == 3) begin
        inv = ~m_q[1];
        if (m_q[2] == inv) begin
          good = 1'b1;
          newc = m_q[1];
          m_q.delete();
        end else begin
          m_errs++;
          m_q.delete();
          if (d == HDR) m_q.push_back(d);
        end
      end
    end else if (m_q.size() > 0 && (m_cyc - m_last_strobe) >= GAP) begin
      m_errs++;
      m_q.delete();
    end
    if (good) begin
      m_press     = newc & ~m_cmd;
      m_cmd       = newc;
      m_stb       = 1'b1;
      m_link      = 1'b1;
      m_last_good = m_cyc;
    end else if ((m_cyc - m_last_good) >= LINK) begin
      m_cmd  = 8'h00;
      m_link = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic check_window(input string name);
    checks++;
    if (win_ok) passed++;
    else $display("[TB] FAIL %s: %s", name, win_msg);
  endtask

  task automatic open_window();
    win_stb   = 0;
    win_press = 8'h00;
    win_ok    = 1'b1;
    win_msg   = "";
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the
  // rising edge, observe the DUT at the next falling edge.
  task automatic tick(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    win_stb   += int'(o_cmd_stb);
    win_press |= o_press;
    if (win_ok && (o_cmd !== m_cmd || o_cmd_stb !== m_stb || o_press !== m_press ||
                   o_link_ok !== m_link || o_err_cnt !== err_exp(m_errs))) begin
      win_ok  = 1'b0;
      win_msg = $sformatf("edge %0d got/exp cmd %02h/%02h stb %0d/%0d press %02h/%02h link %0d/%0d err %02h/%02h",
                          m_cyc, o_cmd, m_cmd, o_cmd_stb, m_stb, o_press, m_press,
                          o_link_ok, m_link, o_err_cnt, err_exp(m_errs));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int plen, input int gap);
    for (int i = 0; i < plen; i++) tick(1'b1, d);
    for (int i = 0; i < gap; i++) tick(1'b0, 8'h00);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b[6];
    int         plen;
    logic [7:0] cmd;
    logic [7:0] press;
    int         stbs;
    int         err_inc;
  } vec_t;

  vec_t vecs[$];

  function void add_vec(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                        input int plen, input logic [7:0] cmd, input logic [7:0] press,
                        input int stbs, input int err_inc);
    vec_t v;
    v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
    v.plen = plen; v.cmd = cmd; v.press = press; v.stbs = stbs; v.err_inc = err_inc;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         err_cum;
    logic [7:0] c;
    logic [7:0] m;
    int         kind;

    add_vec(3, 8'hA5, 8'h12, 8'hED, 8'h00, 8'h00, 8'h00, 2, 8'h12, 8'h12, 1, 0);
    add_vec(3, 8'hA5, 8'h13, 8'hEC, 8'h00, 8'h00, 8'h00, 1, 8'h13, 8'h01, 1, 0);
    add_vec(3, 8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h13, 8'h00, 0, 1);
    add_vec(3, 8'hA5, 8'h13, 8'hEC, 8'h00, 8'h00, 8'h00, 3, 8'h13, 8'h00, 1, 0);
    add_vec(6, 8'h55, 8'hA5, 8'h12, 8'hA5, 8'h40, 8'hBF, 1, 8'h40, 8'h40, 1, 1);
    add_vec(3, 8'hA5, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00, 3, 8'h3C, 8'h3C, 1, 0);
    add_vec(5, 8'h12, 8'hED, 8'hA5, 8'h00, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 1, 0);
    add_vec(3, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 2, 8'hA5, 8'hA5, 1, 0);

    // Reset values.
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    model_reset();
    open_window();
    #1;
    checkOutput("reset cmd", 32'(o_cmd), 32'h00);
    checkOutput("reset stb", 32'(o_cmd_stb), 32'h0);
    checkOutput("reset press", 32'(o_press), 32'h00);
    checkOutput("reset link_ok", 32'(o_link_ok), 32'h0);
    checkOutput("reset err_cnt", 32'(o_err_cnt), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 8'h00);

    // Directed table.
    err_cum = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      open_window();
      for (int k = 0; k < vecs[i].n; k++) applyStimulus(vecs[i].b[k], vecs[i].plen, 2);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      err_cum += vecs[i].err_inc;
      checkOutput($sformatf("vec%0d cmd", i), 32'(o_cmd), 32'(vecs[i].cmd));
      checkOutput($sformatf("vec%0d stb count", i), 32'(win_stb), 32'(vecs[i].stbs));
      checkOutput($sformatf("vec%0d press", i), 32'(win_press), 32'(vecs[i].press));
      checkOutput($sformatf("vec%0d err_cnt", i), 32'(o_err_cnt), 32'(err_exp(err_cum)));
      checkOutput($sformatf("vec%0d link_ok", i), 32'(o_link_ok), 32'h1);
    end

    // Header followed by a long silence: the frame is abandoned.
    open_window();
    applyStimulus(8'hA5, 1, 3227);
    applyStimulus(8'h12, 1, 2);
    applyStimulus(8'hED, 1, 3);
    err_cum++;
    checkOutput("gap abandon cmd", 32'(o_cmd), 32'hA5);
    checkOutput("gap abandon stb count", 32'(win_stb), 32'd0);
    checkOutput("gap abandon err_cnt", 32'(o_err_cnt), 32'(err_exp(err_cum)));
    open_window();
    applyStimulus(8'hA5, 1, 1);
    applyStimulus(8'h34, 1, 1);
    applyStimulus(8'hCB, 1, 3);
    checkOutput("after gap cmd", 32'(o_cmd), 32'h34);
    checkOutput("after gap press", 32'(win_press), 32'h10);

    // Gaps one cycle short of the timeout keep the frame alive.
    open_window();
    applyStimulus(8'hA5, 1, GAP - 1);
    applyStimulus(8'h21, 1, GAP - 1);
    applyStimulus(8'hDE, 1, 3);
    checkOutput("long gap cmd", 32'(o_cmd), 32'h21);
    checkOutput("long gap stb count", 32'(win_stb), 32'd1);
    checkOutput("long gap press", 32'(win_press), 32'h01);
    check_window("directed model agreement");

    // Reset in the middle of a frame.
    applyStimulus(8'hA5, 1, 1);
    applyStimulus(8'h77, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midframe reset cmd", 32'(o_cmd), 32'h00);
    checkOutput("midframe reset link_ok", 32'(o_link_ok), 32'h0);
    checkOutput("midframe reset err_cnt", 32'(o_err_cnt), 32'h00);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    err_cum = 0;
    open_window();
    applyStimulus(8'h88, 1, 3);
    checkOutput("lost frame stb count", 32'(win_stb), 32'd0);
    applyStimulus(8'hA5, 1, 1);
    applyStimulus(8'h77, 1, 1);
    applyStimulus(8'h88, 1, 3);
    checkOutput("post reset cmd", 32'(o_cmd), 32'h77);
    checkOutput("post reset press", 32'(win_press), 32'h77);

    // Random stream against the reference model.
    for (int it = 0; it < 120; it++) begin
      open_window();
      kind = int'($urandom_range(0, 39));
      c = 8'($urandom_range(0, 255));
      m = 8'($urandom_range(1, 255));
      if (kind == 0) begin
        applyStimulus(HDR, int'($urandom_range(1, 3)), GAP + 70);
      end else if (kind < 25) begin
        applyStimulus(HDR, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        applyStimulus(c, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        applyStimulus(~c, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      end else if (kind < 33) begin
        applyStimulus(HDR, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        applyStimulus(c, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        applyStimulus(~c ^ m, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      end else begin
        applyStimulus(c, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      end
      tick(1'b0, 8'h00);
      check_window($sformatf("random item %0d", it));
    end

    // Link timeout: the command drops exactly LINK cycles after a good frame.
    open_window();
    applyStimulus(8'hA5, 1, 1);
    applyStimulus(8'h5C, 1, 1);
    tick(1'b1, 8'hA3);
    checkOutput("good frame latency stb", 32'(o_cmd_stb), 32'h1);
    checkOutput("good frame latency cmd", 32'(o_cmd), 32'h5C);
    win_stb = 0;
    for (int k = 1; k <= LINK; k++) begin
      tick(1'b0, 8'h00);
      if (k == LINK - 1) begin
        checkOutput("link before timeout", 32'({o_link_ok, o_cmd}), 32'h15C);
      end
      if (k == LINK) begin
        checkOutput("link at timeout", 32'({o_link_ok, o_cmd}), 32'h000);
      end
    end
    checkOutput("link timeout stb count", 32'(win_stb), 32'd0);
    check_window("link timeout model agreement");

    // Many bad frames: the error counter saturates.
    open_window();
    for (int k = 0; k < 258; k++) begin
      applyStimulus(8'hA5, 1, 1);
      applyStimulus(8'h00, 1, 1);
      applyStimulus(8'h00, 1, 1);
    end
    checkOutput("err_cnt saturation", 32'(o_err_cnt), 32'(err_exp(258)));
    checkOutput("saturation stb count", 32'(win_stb), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
